mem_responder: RTL and testbench



---
 rtl/mem_responder_pkg.sv | 29 ++
 rtl/mem_responder_if.sv | 27 ++
 rtl/mem_responder_mem_array.sv | 31 +++
 rtl/mem_responder.sv | 119 +++++++++++
 tb/tb_mem_responder.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder slice.
//   state_t    : responder FSM states (S_INIT..S_RESP)
//   NOP..BRZ   : control-unit opcodes, so traffic can be described as RD/WR
//   is_store() : maps a control-unit opcode onto the request write flag
package mem_responder_pkg;

   typedef enum logic [2:0] {
      S_INIT   = 3'd0,
      S_IDLE   = 3'd1,
      S_WAIT   = 3'd2,
      S_ACCESS = 3'd3,
      S_RESP   = 3'd4
   } state_t;

   localparam logic [3:0] NOP = 4'd0;
   localparam logic [3:0] ADD = 4'd1;
   localparam logic [3:0] SUB = 4'd2;
   localparam logic [3:0] AND = 4'd3;
   localparam logic [3:0] NOT = 4'd4;
   localparam logic [3:0] RD  = 4'd5;
   localparam logic [3:0] WR  = 4'd6;
   localparam logic [3:0] BR  = 4'd7;
   localparam logic [3:0] BRZ = 4'd8;

   function automatic logic is_store(input logic [3:0] op);
      return (op == WR);
   endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the processor datapath and the memory responder.
//   req_valid/req_ready : request handshake (write flag, address, store data)
//   rsp_valid/rsp_ready : response handshake (read data, range error)
//   master : requester side, slave : responder side
interface mem_responder_if #(
   parameter int unsigned word_sz = 8
);
   logic               req_valid;
   logic               req_ready;
   logic               req_write;
   logic [word_sz-1:0] req_addr;
   logic [word_sz-1:0] req_wdata;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [word_sz-1:0] rsp_rdata;
   logic               rsp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/mem_responder_mem_array.sv
// Storage array for the memory responder. Contents are never reset.
//   i_clk   : clock
//   i_we    : synchronous write enable
//   i_re    : read enable; o_rdata captures the addressed word on this edge
//   i_addr  : word index (already range-checked by the caller)
//   i_wdata : store data
//   o_rdata : registered read data, held until the next enabled read
module mem_array #(
   parameter int unsigned word_sz = 8,
   parameter int unsigned mem_sz  = 256,
   parameter int unsigned addr_w  = 8
) (
   input  logic               i_clk,
   input  logic               i_we,
   input  logic               i_re,
   input  logic [addr_w-1:0]  i_addr,
   input  logic [word_sz-1:0] i_wdata,
   output logic [word_sz-1:0] o_rdata
);

   logic [word_sz-1:0] r_mem [mem_sz];
   logic [word_sz-1:0] r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
      if (i_re) r_rdata <= r_mem[i_addr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Handshaked memory responder with programmable wait states.
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   bus : slave side of mem_responder_if (request and response channels)
// Every bus output is a register or a decode of registered state.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int unsigned word_sz     = 8,
   parameter int unsigned mem_sz      = 256,
   parameter int unsigned wait_cycles = 2
) (
   input  logic           clk,
   input  logic           rst,
   mem_responder_if.slave bus
);

   localparam int unsigned ADDR_W    = (mem_sz > 1) ? $clog2(mem_sz) : 1;
   localparam logic [3:0]  WAIT_LOAD = 4'(wait_cycles);

   state_t             r_state, w_state_nxt;
   logic [3:0]         r_cnt, w_cnt_nxt;
   logic               w_latch;
   logic               r_write;
   logic [word_sz-1:0] r_addr;
   logic [word_sz-1:0] r_wdata;
   logic [word_sz-1:0] r_rsp_rdata;
   logic               r_rsp_err;
   logic               r_rd_sel;
   logic               w_in_range;
   logic               w_we;
   logic               w_re;
   logic [word_sz-1:0] w_arr_rdata;

   // Unsigned compare on the full address: nothing past mem_sz aliases.
   assign w_in_range = (32'(r_addr) < mem_sz);
   assign w_we       = (r_state == S_ACCESS) && w_in_range && r_write;
   assign w_re       = (r_state == S_ACCESS) && w_in_range && !r_write;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_INIT;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_latch     = 1'b0;
      case (r_state)
         S_INIT:   w_state_nxt = S_IDLE;
         S_IDLE: begin
            if (bus.req_valid) begin
               w_latch = 1'b1;
               if (wait_cycles == 0) begin
                  w_state_nxt = S_ACCESS;
               end else begin
                  w_cnt_nxt   = WAIT_LOAD;
                  w_state_nxt = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            w_cnt_nxt = r_cnt - 4'd1;
            if (r_cnt <= 4'd1) w_state_nxt = S_ACCESS;
         end
         S_ACCESS: w_state_nxt = S_RESP;
         S_RESP:   if (bus.rsp_ready) w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_INIT;
      endcase
   end

   // Loads return the array's own read register (r_rd_sel) instead of copying
   // it, so the registered read lands exactly as S_ACCESS hands over to S_RESP.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_write     <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
         r_rd_sel    <= 1'b0;
      end else begin
         if (w_latch) begin
            r_write <= bus.req_write;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
         end
         if (r_state == S_ACCESS) begin
            r_rsp_err   <= !w_in_range;
            r_rd_sel    <= w_in_range && !r_write;
            r_rsp_rdata <= (w_in_range && r_write) ? r_wdata : '0;
         end
      end
   end

   mem_array #(
      .word_sz (word_sz),
      .mem_sz  (mem_sz),
      .addr_w  (ADDR_W)
   ) u_mem_array (
      .i_clk   (clk),
      .i_we    (w_we),
      .i_re    (w_re),
      .i_addr  (r_addr[ADDR_W-1:0]),
      .i_wdata (r_wdata),
      .o_rdata (w_arr_rdata)
   );

   assign bus.req_ready = (r_state == S_IDLE);
   assign bus.rsp_valid = (r_state == S_RESP);
   assign bus.rsp_rdata = r_rd_sel ? w_arr_rdata : r_rsp_rdata;
   assign bus.rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder. Three instances:
//   0 : mem_sz=256, wait_cycles=2
//   1 : mem_sz=256, wait_cycles=0
//   2 : mem_sz=128, wait_cycles=2
// Expected responses come from a word-array model per instance.
module tb_mem_responder;
   import mem_responder_pkg::*;

   logic       clk = 1'b0;
   int         cyc = 0;
   int         n_vec = 0;
   int         n_bad = 0;

   logic       tb_rst       [3];
   logic       tb_req_valid [3];
   logic       tb_req_write [3];
   logic [7:0] tb_req_addr  [3];
   logic [7:0] tb_req_wdata [3];
   logic       tb_rsp_ready [3];
   logic       tb_req_ready [3];
   logic       tb_rsp_valid [3];
   logic [7:0] tb_rsp_rdata [3];
   logic       tb_rsp_err   [3];

   logic [7:0] m_mem   [3][256];
   bit         m_known [3][256];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int unsigned W = (g == 1) ? 0 : 2;
      localparam int unsigned M = (g == 2) ? 128 : 256;
      mem_responder_if #(.word_sz(8)) bus ();
      assign bus.req_valid   = tb_req_valid[g];
      assign bus.req_write   = tb_req_write[g];
      assign bus.req_addr    = tb_req_addr[g];
      assign bus.req_wdata   = tb_req_wdata[g];
      assign bus.rsp_ready   = tb_rsp_ready[g];
      assign tb_req_ready[g] = bus.req_ready;
      assign tb_rsp_valid[g] = bus.rsp_valid;
      assign tb_rsp_rdata[g] = bus.rsp_rdata;
      assign tb_rsp_err[g]   = bus.rsp_err;
      mem_responder #(
         .word_sz     (8),
         .mem_sz      (M),
         .wait_cycles (W)
      ) u_dut (
         .clk (clk),
         .rst (tb_rst[g]),
         .bus (bus)
      );
   end

   function automatic int waits(input int i);
      return (i == 1) ? 0 : 2;
   endfunction

   function automatic int mems(input int i);
      return (i == 2) ? 128 : 256;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Presents a request from a negedge and holds it until accepted. n0 is the
   // cycle count at the negedge where req_ready was seen high; the accepting
   // edge is therefore n0+1.
   task automatic send_req(input int i, input bit wr, input logic [7:0] a,
                           input logic [7:0] d, output int n0, output bit ok);
      @(negedge clk);
      tb_req_valid[i] = 1'b1;
      tb_req_write[i] = wr;
      tb_req_addr[i]  = a;
      tb_req_wdata[i] = d;
      ok = 1'b0;
      n0 = cyc;
      for (int k = 0; k < 100; k++) begin
         if (tb_req_ready[i]) begin
            ok = 1'b1;
            n0 = cyc;
            break;
         end
         @(negedge clk);
      end
      if (!ok) chk($sformatf("req_timeout%0d", i), 32'(tb_req_ready[i]), 1);
      @(posedge clk);
      #1 tb_req_valid[i] = 1'b0;
   endtask

   task automatic get_rsp(input int i, input int n0, output int lat, output bit ok);
      ok  = 1'b0;
      lat = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (tb_rsp_valid[i]) begin
            ok = 1'b1;
            break;
         end
      end
      lat = cyc - n0;
      if (!ok) chk($sformatf("rsp_timeout%0d", i), 32'(tb_rsp_valid[i]), 1);
   endtask

   // Called at the negedge where the response is first visible.
   task automatic release_rsp(input int i, input int hold, input logic [7:0] rd_e,
                              input bit err_e, input bit known);
      tb_rsp_ready[i] = 1'b0;
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         chk($sformatf("hold_valid%0d", i), 32'(tb_rsp_valid[i]), 1);
         chk($sformatf("hold_ready%0d", i), 32'(tb_req_ready[i]), 0);
         chk($sformatf("hold_err%0d", i), 32'(tb_rsp_err[i]), 32'(err_e));
         if (known) chk($sformatf("hold_data%0d", i), 32'(tb_rsp_rdata[i]), 32'(rd_e));
      end
      tb_rsp_ready[i] = 1'b1;
      @(negedge clk);
      tb_rsp_ready[i] = 1'b0;
      chk($sformatf("drop_valid%0d", i), 32'(tb_rsp_valid[i]), 0);
      chk($sformatf("back_ready%0d", i), 32'(tb_req_ready[i]), 1);
   endtask

   task automatic txn(input int i, input logic [3:0] op, input logic [7:0] a,
                      input logic [7:0] d, input int hold);
      bit         wr, err_e, known, ok;
      logic [7:0] rd_e;
      int         n0, lat;
      wr    = is_store(op);
      err_e = (int'(a) >= mems(i));
      known = err_e || wr || m_known[i][a];
      rd_e  = err_e ? 8'h00 : (wr ? d : m_mem[i][a]);
      send_req(i, wr, a, d, n0, ok);
      if (ok) begin
         get_rsp(i, n0, lat, ok);
         if (ok) begin
            chk($sformatf("lat%0d_%0h", i, a), 32'(lat), 32'(waits(i) + 2));
            chk($sformatf("err%0d_%0h", i, a), 32'(tb_rsp_err[i]), 32'(err_e));
            if (known) chk($sformatf("data%0d_%0h", i, a), 32'(tb_rsp_rdata[i]), 32'(rd_e));
            release_rsp(i, hold, rd_e, err_e, known);
         end
      end
      if (wr && !err_e) begin
         m_mem[i][a]   = d;
         m_known[i][a] = 1'b1;
      end
   endtask

   initial begin
      int  n0, lat;
      bit  ok;
      for (int i = 0; i < 3; i++) begin
         tb_rst[i]       = 1'b0;
         tb_req_valid[i] = 1'b0;
         tb_req_write[i] = 1'b0;
         tb_req_addr[i]  = '0;
         tb_req_wdata[i] = '0;
         tb_rsp_ready[i] = 1'b0;
      end

      // Reset then idle.
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst_ready%0d", i), 32'(tb_req_ready[i]), 0);
         chk($sformatf("rst_valid%0d", i), 32'(tb_rsp_valid[i]), 0);
         chk($sformatf("rst_data%0d", i), 32'(tb_rsp_rdata[i]), 0);
         chk($sformatf("rst_err%0d", i), 32'(tb_rsp_err[i]), 0);
         tb_rst[i] = 1'b1;
      end
      #1 chk("init_ready", 32'(tb_req_ready[0]), 0);
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("idle_ready%0d", i), 32'(tb_req_ready[i]), 1);
         chk($sformatf("idle_valid%0d", i), 32'(tb_rsp_valid[i]), 0);
      end

      // Store then load, two wait states.
      txn(0, WR, 8'h10, 8'hA5, 0);
      txn(0, RD, 8'h10, 8'h00, 0);

      // Zero wait states.
      txn(1, WR, 8'h00, 8'h3C, 0);
      txn(1, RD, 8'h00, 8'h00, 0);

      // Back-pressure with a second request waiting during S_RESP.
      send_req(0, 1'b1, 8'h30, 8'h5A, n0, ok);
      get_rsp(0, n0, lat, ok);
      chk("bp_lat", 32'(lat), 4);
      m_mem[0][8'h30]   = 8'h5A;
      m_known[0][8'h30] = 1'b1;
      tb_req_valid[0] = 1'b1;
      tb_req_write[0] = 1'b0;
      tb_req_addr[0]  = 8'h30;
      tb_req_wdata[0] = 8'h00;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_valid", 32'(tb_rsp_valid[0]), 1);
         chk("bp_data", 32'(tb_rsp_rdata[0]), 32'h5A);
         chk("bp_err", 32'(tb_rsp_err[0]), 0);
         chk("bp_ready", 32'(tb_req_ready[0]), 0);
      end
      tb_rsp_ready[0] = 1'b1;
      @(negedge clk);
      tb_rsp_ready[0] = 1'b0;
      chk("bp_drop", 32'(tb_rsp_valid[0]), 0);
      chk("bp_reready", 32'(tb_req_ready[0]), 1);
      n0 = cyc;
      @(posedge clk);
      #1 tb_req_valid[0] = 1'b0;
      get_rsp(0, n0, lat, ok);
      chk("bp2_lat", 32'(lat), 4);
      chk("bp2_data", 32'(tb_rsp_rdata[0]), 32'h5A);
      release_rsp(0, 0, 8'h5A, 1'b0, 1'b1);

      // Out of range, mem_sz=128.
      txn(2, WR, 8'h00, 8'h11, 0);
      txn(2, WR, 8'h7F, 8'hC3, 1);
      txn(2, WR, 8'h80, 8'hFF, 2);
      txn(2, RD, 8'h00, 8'h00, 0);
      txn(2, RD, 8'h7F, 8'h00, 0);

      // Reset during S_WAIT drops the store.
      txn(0, WR, 8'h20, 8'h96, 0);
      send_req(0, 1'b1, 8'h20, 8'h77, n0, ok);
      @(negedge clk);
      tb_rst[0] = 1'b0;
      #1;
      chk("mid_rst_ready", 32'(tb_req_ready[0]), 0);
      chk("mid_rst_valid", 32'(tb_rsp_valid[0]), 0);
      @(negedge clk);
      tb_rst[0] = 1'b1;
      #1 chk("mid_rel_ready", 32'(tb_req_ready[0]), 0);
      txn(0, RD, 8'h20, 8'h00, 0);

      // Randomized traffic against the model.
      for (int i = 0; i < 3; i++) begin
         for (int k = 0; k < 30; k++) begin
            logic [3:0] op;
            logic [7:0] a;
            op = ($urandom_range(0, 1) == 1) ? WR : RD;
            a  = (i == 2) ? 8'($urandom_range(100, 160)) : 8'($urandom_range(0, 31));
            txn(i, op, a, 8'($urandom), int'($urandom_range(0, 3)));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
